// File: rtl/cla_pkg.sv
// Shared constants, group-count helper and stage-1 register layout for the
// pipelined carry-lookahead adder.
package cla_pkg;

  localparam int GRP_W     = 4;
  localparam int MAX_WIDTH = 16;
  localparam int MAX_GRP   = MAX_WIDTH / GRP_W;

  // Number of 4-bit lookahead groups needed to cover an operand width.
  function automatic int grp_count(input int width);
    return width / GRP_W;
  endfunction

  // Everything stage 2 needs to finish the add: bit and group propagate /
  // generate terms, the effective carry-in, and the operand sign bits used
  // for signed overflow. Sized for the widest build; narrower builds leave
  // the upper bits at zero.
  typedef struct packed {
    logic [MAX_WIDTH-1:0] p;
    logic [MAX_WIDTH-1:0] g;
    logic [MAX_GRP-1:0]   gp;
    logic [MAX_GRP-1:0]   gg;
    logic                 cin;
    logic                 a_msb;
    logic                 bb_msb;
  } stage1_t;

endpackage

// File: rtl/cla_pipe_adder_lcu4.sv
// 4-bit lookahead carry unit: bit carries from a carry-in plus group
// propagate / generate for the next lookahead level.
module lcu4
  import cla_pkg::*;
(
  input  logic             c_in,
  input  logic [GRP_W-1:0] P,
  input  logic [GRP_W-1:0] G,
  output logic [GRP_W:1]   carry,
  output logic             P_out,
  output logic             G_out
);

  // Unrolled lookahead recurrence; flattens to sum-of-products logic.
  always_comb begin
    logic c_acc_s;
    logic g_acc_s;
    carry   = '0;
    c_acc_s = c_in;
    g_acc_s = 1'b0;
    for (int i = 0; i < GRP_W; i++) begin
      c_acc_s      = G[i] | (P[i] & c_acc_s);
      g_acc_s      = G[i] | (P[i] & g_acc_s);
      carry[i + 1] = c_acc_s;
    end
    P_out = &P;
    G_out = g_acc_s;
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// handshakes on both sides and carry / overflow / zero flags.
// Stage 1 registers bit and group P/G; stage 2 resolves carries through a
// top-level lookahead unit and registers the result.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NGRP = grp_count(WIDTH);

  // Operand preparation and per-bit terms
  logic [WIDTH-1:0] bb_s;
  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] g_s;
  logic             cin0_s;
  logic [NGRP-1:0]  gp_s;
  logic [NGRP-1:0]  gg_s;
  logic [GRP_W:1]   s1_carry_unused_s [NGRP];

  // Pipeline state
  stage1_t          s1_d, s1_q;
  logic             v1_d, v1_q;
  logic             v2_d, v2_q;
  logic             adv1_s, adv2_s;

  // Stage-2 carry resolution
  logic [MAX_GRP-1:0] top_gp_s;
  logic [MAX_GRP-1:0] top_gg_s;
  logic [GRP_W:1]     top_carry_s;
  logic               top_p_unused_s, top_g_unused_s, top_cout_unused_s;
  logic [NGRP-1:0]    grp_cin_s;
  logic [GRP_W:1]     s2_carry_s [NGRP];
  logic [NGRP-1:0]    s2_p_unused_s, s2_g_unused_s;
  logic [WIDTH:0]     c_s;
  logic [WIDTH-1:0]   sum_s;
  logic               ovf_s;

  // Output register
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             c_out_d, c_out_q;
  logic             ovf_d, ovf_q;
  logic             zero_d, zero_q;

  // Subtract is A + ~B + 1; add uses the external carry-in.
  always_comb begin
    bb_s   = b;
    cin0_s = c_in;
    if (sub) begin
      bb_s   = ~b;
      cin0_s = 1'b1;
    end else begin
      bb_s   = b;
      cin0_s = c_in;
    end
    p_s = a ^ bb_s;
    g_s = a & bb_s;
  end

  // First-level lookahead: group propagate / generate from each nibble.
  for (genvar k = 0; k < NGRP; k++) begin : g_s1_grp
    lcu4 u_s1_lcu4 (
      .c_in  (1'b0),
      .P     (p_s[k*GRP_W +: GRP_W]),
      .G     (g_s[k*GRP_W +: GRP_W]),
      .carry (s1_carry_unused_s[k]),
      .P_out (gp_s[k]),
      .G_out (gg_s[k])
    );
  end

  // Handshake: stage 2 moves when it is empty or being drained; stage 1
  // accepts when it is empty or handing its beat to stage 2.
  always_comb begin
    adv2_s   = v1_q & (~v2_q | out_ready);
    in_ready = ~v1_q | adv2_s;
    adv1_s   = in_valid & in_ready;
  end

  // Stage-1 next state: capture a new beat or hold the current one.
  always_comb begin
    s1_d = s1_q;
    v1_d = v1_q;
    if (adv1_s) begin
      s1_d                   = '0;
      s1_d.p[WIDTH-1:0]      = p_s;
      s1_d.g[WIDTH-1:0]      = g_s;
      s1_d.gp[NGRP-1:0]      = gp_s;
      s1_d.gg[NGRP-1:0]      = gg_s;
      s1_d.cin               = cin0_s;
      s1_d.a_msb             = a[WIDTH-1];
      s1_d.bb_msb            = bb_s[WIDTH-1];
      v1_d                   = 1'b1;
    end else if (adv2_s) begin
      v1_d = 1'b0;
    end else begin
      v1_d = v1_q;
    end
  end

  // Top-level lookahead input; lanes beyond NGRP are tied to P=0, G=0.
  always_comb begin
    top_gp_s               = '0;
    top_gg_s               = '0;
    top_gp_s[NGRP-1:0]     = s1_q.gp[NGRP-1:0];
    top_gg_s[NGRP-1:0]     = s1_q.gg[NGRP-1:0];
  end

  lcu4 u_top_lcu4 (
    .c_in  (s1_q.cin),
    .P     (top_gp_s),
    .G     (top_gg_s),
    .carry (top_carry_s),
    .P_out (top_p_unused_s),
    .G_out (top_g_unused_s)
  );

  // The overall carry-out is taken from the last group's bit carries instead.
  assign top_cout_unused_s = top_carry_s[GRP_W];

  // Group carry-ins: C_0 is the effective carry-in, the rest come from the top unit.
  always_comb begin
    grp_cin_s    = '0;
    grp_cin_s[0] = s1_q.cin;
    for (int k = 1; k < NGRP; k++) begin
      grp_cin_s[k] = top_carry_s[k];
    end
  end

  // Second-level lookahead: bit carries inside each group.
  for (genvar k = 0; k < NGRP; k++) begin : g_s2_grp
    lcu4 u_s2_lcu4 (
      .c_in  (grp_cin_s[k]),
      .P     (s1_q.p[k*GRP_W +: GRP_W]),
      .G     (s1_q.g[k*GRP_W +: GRP_W]),
      .carry (s2_carry_s[k]),
      .P_out (s2_p_unused_s[k]),
      .G_out (s2_g_unused_s[k])
    );
  end

  // Gather bit carries, form the sum and signed overflow.
  always_comb begin
    c_s    = '0;
    c_s[0] = s1_q.cin;
    for (int k = 0; k < NGRP; k++) begin
      for (int j = 1; j <= GRP_W; j++) begin
        c_s[k*GRP_W + j] = s2_carry_s[k][j];
      end
    end
    sum_s = s1_q.p[WIDTH-1:0] ^ c_s[WIDTH-1:0];
    ovf_s = (s1_q.a_msb ~^ s1_q.bb_msb) & (sum_s[WIDTH-1] ^ s1_q.a_msb);
  end

  // Output register next state: load on advance, otherwise hold for backpressure.
  always_comb begin
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    v2_d    = v2_q;
    if (adv2_s) begin
      sum_d   = sum_s;
      c_out_d = c_s[WIDTH];
      ovf_d   = ovf_s;
      zero_d  = ~|sum_s;
      v2_d    = 1'b1;
    end else if (out_ready) begin
      v2_d = 1'b0;
    end else begin
      v2_d = v2_q;
    end
  end

  // Pipeline and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign out_valid = v2_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: arithmetic reference model with a
// scoreboard queue, plus directed literal checks.
module tb_cla_pipe_adder;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, in_ready, sub, c_in, out_valid, out_ready, c_out, ovf, zero;
  logic [W-1:0] a, b, sum;

  logic       in_valid8, in_ready8, sub8, c_in8, out_valid8, out_ready8, c_out8, ovf8, zero8;
  logic [7:0] a8, b8, sum8;

  cla_pipe_adder #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .c_in(c_in), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf), .zero(zero)
  );

  cla_pipe_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub8), .c_in(c_in8), .out_valid(out_valid8),
    .out_ready(out_ready8), .sum(sum8), .c_out(c_out8), .ovf(ovf8), .zero(zero8)
  );

  typedef struct {
    longint sum;
    bit     c_out;
    bit     ovf;
    bit     zero;
    int     cyc;
  } exp_t;

  int     n_chk = 0;
  int     n_fail = 0;
  int     cyc = 0;
  bit     strict_lat = 1'b0;
  exp_t   sb_q[$];
  longint popped[$];

  // Plain integer arithmetic: unsigned result, no-borrow carry, signed range test.
  function automatic exp_t model(input int w, input longint x, input longint y,
                                 input bit s, input bit ci);
    exp_t   e;
    longint m    = longint'(1) << w;
    longint half = m >> 1;
    longint r, sx, sy, sr;
    sx = (x >= half) ? x - m : x;
    sy = (y >= half) ? y - m : y;
    if (s) begin
      r       = x - y;
      e.c_out = (x >= y);
      sr      = sx - sy;
    end else begin
      r       = x + y + longint'(ci);
      e.c_out = (r >= m);
      sr      = sx + sy + longint'(ci);
    end
    e.sum  = ((r % m) + m) % m;
    e.ovf  = (sr >= half) || (sr < -half);
    e.zero = (e.sum == 0);
    e.cyc  = 0;
    return e;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: looks at what will transfer on the coming rising edge.
  bit           have_hold = 1'b0;
  logic [W-1:0] hold_sum;
  logic         hold_c, hold_o, hold_z;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      sb_q.delete();
      have_hold = 1'b0;
    end else begin
      if (have_hold) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_sum", sum, hold_sum);
        check("hold_flags", {c_out, ovf, zero}, {hold_c, hold_o, hold_z});
      end
      have_hold = 1'b0;
      if (out_valid === 1'b1 && out_ready !== 1'b1) begin
        have_hold = 1'b1;
        hold_sum  = sum;
        hold_c    = c_out;
        hold_o    = ovf;
        hold_z    = zero;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("spurious_beat", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_sum", sum, e.sum);
          check("sb_c_out", c_out, e.c_out);
          check("sb_ovf", ovf, e.ovf);
          check("sb_zero", zero, e.zero);
          if (strict_lat) check("sb_latency", cyc - e.cyc, 2);
          popped.push_back(longint'(sum));
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        exp_t e;
        e     = model(W, longint'(a), longint'(b), sub, c_in);
        e.cyc = cyc;
        sb_q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic s, input logic ci);
    bit done = 1'b0;
    in_valid = 1'b1; a = x; b = y; sub = s; c_in = ci;
    #1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready === 1'b1) done = 1'b1;
      step();
    end
    if (!done) check("send_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && (sb_q.size() != 0 || out_valid === 1'b1); i++) step();
    check("drain_empty", sb_q.size(), 0);
  endtask

  task automatic expect_res(input string nm, input logic [W-1:0] es,
                            input logic ec, input logic eo, input logic ez);
    check({nm, "_early"}, out_valid, 1'b0);
    step();
    check({nm, "_valid"}, out_valid, 1'b1);
    check({nm, "_sum"}, sum, es);
    check({nm, "_flags"}, {c_out, ovf, zero}, {ec, eo, ez});
  endtask

  initial begin
    int base;
    exp_t e8;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; c_in = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; c_in8 = 1'b0; out_ready8 = 1'b1;

    // Model pinned to hand-computed values
    e8 = model(16, 64'hFFFF, 64'h1, 1'b0, 1'b0);
    check("model_wrap", {e8.sum[15:0], e8.c_out, e8.ovf, e8.zero}, {16'h0000, 3'b101});
    e8 = model(16, 64'h8000, 64'h1, 1'b1, 1'b0);
    check("model_sub", {e8.sum[15:0], e8.c_out, e8.ovf, e8.zero}, {16'h7FFF, 3'b110});

    // Reset state
    repeat (3) step();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out", {out_valid, sum, c_out, ovf, zero}, '0);
    rst_n = 1'b1;
    step();

    // Wrap to zero, signed overflow on add and on subtract
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    expect_res("t1", 16'h0000, 1'b1, 1'b0, 1'b1);
    drain();
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    expect_res("t2a", 16'h8000, 1'b0, 1'b1, 1'b0);
    drain();
    send(16'h8000, 16'h0001, 1'b1, 1'b0);
    expect_res("t2b", 16'h7FFF, 1'b1, 1'b1, 1'b0);
    drain();

    // Back-to-back random stream, full throughput, fixed latency
    strict_lat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      a = 16'($urandom_range(0, 65535)); b = 16'($urandom_range(0, 65535));
      sub = 1'($urandom_range(0, 1)); c_in = 1'($urandom_range(0, 1));
      #1;
      check("t3_in_ready", in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;
    drain();
    strict_lat = 1'b0;

    // Backpressure: two beats held, output frozen, then released in order
    base = popped.size();
    send(16'h0001, 16'h0001, 1'b0, 1'b0);
    out_ready = 1'b0;
    send(16'h0002, 16'h0002, 1'b0, 1'b0);
    in_valid = 1'b1; a = 16'h0003; b = 16'h0003; sub = 1'b0; c_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_in_ready_low", in_ready, 1'b0);
      check("t4_held", {out_valid, sum}, {1'b1, 16'h0002});
      step();
    end
    out_ready = 1'b1;
    send(16'h0003, 16'h0003, 1'b0, 1'b0);
    send(16'h0004, 16'h0004, 1'b0, 1'b0);
    drain();
    check("t4_count", popped.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < popped.size()) check("t4_order", popped[base + i], 2 * (i + 1));

    // Reset with two beats in flight, beat offered during reset is dropped
    send(16'h0011, 16'h0022, 1'b0, 1'b0);
    send(16'h0033, 16'h0044, 1'b0, 1'b0);
    rst_n = 1'b0; in_valid = 1'b1; a = 16'h1234; b = 16'h0001;
    step();
    check("t5_rst_out", {out_valid, sum}, '0);
    check("t5_rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t5_no_stale", out_valid, 1'b0);
      step();
    end
    send(16'h0005, 16'h0003, 1'b0, 1'b0);
    expect_res("t5_new", 16'h0008, 1'b0, 1'b0, 1'b0);
    drain();

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = 16'($urandom_range(0, 65535)); b = 16'($urandom_range(0, 65535));
      sub = 1'($urandom_range(0, 1)); c_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin b = a; sub = 1'b1; end
      if ($urandom_range(0, 9) == 0) begin a = 16'hFFFF; b = 16'h0000; c_in = 1'b1; sub = 1'b0; end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // Narrow build: carry crosses the nibble boundary
    in_valid8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; sub8 = 1'b0; c_in8 = 1'b1;
    #1;
    check("t6_in_ready", in_ready8, 1'b1);
    step();
    in_valid8 = 1'b0;
    check("t6_early", out_valid8, 1'b0);
    step();
    check("t6_res", {out_valid8, sum8, c_out8, ovf8, zero8}, {1'b1, 8'h11, 3'b000});
    for (int i = 0; i < 6; i++) begin
      in_valid8 = 1'b1;
      a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
      sub8 = 1'($urandom_range(0, 1)); c_in8 = 1'($urandom_range(0, 1));
      e8 = model(8, longint'(a8), longint'(b8), sub8, c_in8);
      #1;
      step();
      in_valid8 = 1'b0;
      step();
      check("w8_res", {out_valid8, sum8, c_out8, ovf8, zero8},
            {1'b1, e8.sum[7:0], e8.c_out, e8.ovf, e8.zero});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
